// File: rtl/dice_pkg.sv
// Shared types and helpers for the dice counters: die value type, face
// limits and the wrapped-successor function used by each die.
package dice_pkg;

  localparam int DIE_WIDTH = 3;

  typedef logic [DIE_WIDTH-1:0] die_t;

  localparam die_t DIE_MIN       = die_t'(1);
  localparam int   DIE_MAX_FACES = (1 << DIE_WIDTH) - 1;

  // True when value lies in the counting range 1..faces.
  function automatic logic is_legal(input die_t value, input die_t faces);
    return (value >= DIE_MIN) && (value <= faces);
  endfunction

  // Successor of a face value; the top face and any illegal value map to 1.
  function automatic die_t next_face(input die_t value, input die_t faces);
    if ((value >= DIE_MIN) && (value < faces)) begin
      return value + die_t'(1);
    end
    return DIE_MIN;
  endfunction

endpackage

// File: rtl/dice_counters_die_counter.sv
// One modulo-FACES die counting 1..FACES. Advances on inc; wrap flags the
// edge on which a legal top face rolls over to 1.
module die_counter
  import dice_pkg::*;
#(
  parameter int FACES = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  output die_t value,
  output logic wrap
);

  localparam die_t TOP = die_t'(FACES);

  logic legal;

  assign legal = is_legal(value, TOP);
  assign wrap  = inc && (value == TOP);

  // An illegal value recovers to 1 on the next edge even when inc is low,
  // and never produces a carry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= DIE_MIN;
    end else if (!legal) begin
      value <= DIE_MIN;
    end else if (inc) begin
      value <= next_face(value, TOP);
    end
  end

endmodule

// File: rtl/dice_counters.sv
// Pair of chained dice counters: dice1 steps every clock, dice2 steps when
// dice1 wraps. Optional doubles output under macro DICE_DOUBLES_EN.
module dice_counters
  import dice_pkg::*;
#(
  parameter int FACES = 6
) (
  input  logic clk,
  input  logic rst,
  output die_t dice1_out,
  output die_t dice2_out
`ifdef DICE_DOUBLES_EN
  ,
  output logic doubles
`endif
);

  logic dice1_wrap;
  logic dice2_wrap;

  die_counter #(.FACES(FACES)) u_dice1 (
    .clk   (clk),
    .rst   (rst),
    .inc   (1'b1),
    .value (dice1_out),
    .wrap  (dice1_wrap)
  );

  die_counter #(.FACES(FACES)) u_dice2 (
    .clk   (clk),
    .rst   (rst),
    .inc   (dice1_wrap),
    .value (dice2_out),
    .wrap  (dice2_wrap)
  );

`ifdef DICE_DOUBLES_EN
  // Decoded from the registered values, so it reads 1 throughout reset.
  assign doubles = (dice1_out == dice2_out);
`endif

  logic unused_dice2_wrap;
  assign unused_dice2_wrap = dice2_wrap;

endmodule

// File: tb/tb_dice_counters.sv
// Directed bench for dice_counters with FACES=6: reset, carry, full period
// coverage, double wrap and asynchronous reset mid-count.
module tb_dice_counters;

  localparam int FACES = 6;

  logic       clk;
  logic       rst;
  logic [2:0] dice1_out;
  logic [2:0] dice2_out;
`ifdef DICE_DOUBLES_EN
  logic       doubles;
`endif

  dice_counters #(.FACES(FACES)) dut (
    .clk       (clk),
    .rst       (rst),
    .dice1_out (dice1_out),
    .dice2_out (dice2_out)
`ifdef DICE_DOUBLES_EN
    ,
    .doubles   (doubles)
`endif
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int tests_run;
  int tests_failed;

  logic [5:0] exp_q[$];
  int m1;
  int m2;
  int seen [1:6][1:6];
  int doubles_cnt;

  task automatic check(input string tag, input int got, input int exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference odometer: advance the expected pair and queue it.
  task automatic model_step();
    if (m1 == FACES) begin
      m1 = 1;
      m2 = (m2 == FACES) ? 1 : m2 + 1;
    end else begin
      m1 = m1 + 1;
    end
    exp_q.push_back({m2[2:0], m1[2:0]});
  endtask

  task automatic model_reset();
    m1 = 1;
    m2 = 1;
    exp_q.delete();
  endtask

  task automatic score(input string tag);
    logic [5:0] exp;
    if (exp_q.size() == 0) begin
      check({tag, "_queue_empty"}, 0, 1);
    end else begin
      exp = exp_q.pop_front();
      check({tag, "_d1"}, int'(dice1_out), int'(exp[2:0]));
      check({tag, "_d2"}, int'(dice2_out), int'(exp[5:3]));
    end
  endtask

  task automatic step_and_score(input string tag);
    tick();
    model_step();
    score(tag);
  endtask

  task automatic check_pair(input string tag, input int a, input int b);
    check({tag, "_d1"}, int'(dice1_out), a);
    check({tag, "_d2"}, int'(dice2_out), b);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    doubles_cnt  = 0;
    for (int a = 1; a <= 6; a++)
      for (int b = 1; b <= 6; b++)
        seen[a][b] = 0;
    model_reset();

    // reset held 0..10 ns, spanning the edge at 5 ns
    rst = 1'b1;
    #2;
    check_pair("reset_early", 1, 1);
`ifdef DICE_DOUBLES_EN
    check("reset_doubles", int'(doubles), 1);
`endif
    #5;
    check_pair("reset_after_edge", 1, 1);
    #3;
    rst = 1'b0;

    // one full period from release
    for (int i = 1; i <= 36; i++) begin
      step_and_score($sformatf("period_%0d", i));
      check($sformatf("range_%0d", i),
            int'(dice1_out >= 3'd1 && dice1_out <= 3'd6 &&
                 dice2_out >= 3'd1 && dice2_out <= 3'd6), 1);
      if (dice1_out >= 3'd1 && dice1_out <= 3'd6 &&
          dice2_out >= 3'd1 && dice2_out <= 3'd6)
        seen[dice1_out][dice2_out]++;
`ifdef DICE_DOUBLES_EN
      check($sformatf("doubles_%0d", i), int'(doubles), int'(m1 == m2));
      if (doubles) doubles_cnt++;
`endif
      if (i == 1)  check_pair("first_edge", 2, 1);
      if (i == 5)  check_pair("before_wrap", 6, 1);
      if (i == 6)  check_pair("carry", 1, 2);
      if (i == 35) check_pair("top_pair", 6, 6);
      if (i == 36) check_pair("double_wrap", 1, 1);
    end
    for (int a = 1; a <= 6; a++)
      for (int b = 1; b <= 6; b++)
        check($sformatf("seen_%0d_%0d", a, b), seen[a][b], 1);
`ifdef DICE_DOUBLES_EN
    check("doubles_per_period", doubles_cnt, 6);
`endif

    // run on to (4,3): 3 + 2*6 edges after (1,1)
    for (int i = 1; i <= 15; i++)
      step_and_score($sformatf("run_%0d", i));
    check_pair("pre_async", 4, 3);

    // async reset between edges
    #($urandom_range(1, 3));
    rst = 1'b1;
    #1;
    check_pair("async_immediate", 1, 1);
`ifdef DICE_DOUBLES_EN
    check("async_doubles", int'(doubles), 1);
`endif
    tick();
    check_pair("async_hold_1", 1, 1);
    tick();
    check_pair("async_hold_2", 1, 1);
    #3;
    rst = 1'b0;
    model_reset();
    step_and_score("resume_1");
    check_pair("resume_first", 2, 1);
    for (int i = 2; i <= 8; i++)
      step_and_score($sformatf("resume_%0d", i));
    check_pair("resume_carry", 3, 2);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
